// File: rtl/cic_decimator_n_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cic_decimator_n_if : sample-in / decimated-sample-out bus of the CIC decimator
// Revision: 1.0
// ---------------------------------------------------------------------------
interface cic_decimator_n_if #(
  parameter int INPUT_WIDTH  = 12,
  parameter int OUTPUT_WIDTH = 16,
  parameter int MAX_R        = 8
);
  localparam int RW = $clog2(MAX_R + 1);

  logic                           enable;
  logic                           clear;
  logic        [RW-1:0]           rate;
  logic                           in_valid;
  logic signed [INPUT_WIDTH-1:0]  in_data;
  logic                           out_valid;
  logic signed [OUTPUT_WIDTH-1:0] out_data;
  logic        [RW-1:0]           rate_active;

  modport master (
    output enable, clear, rate, in_valid, in_data,
    input  out_valid, out_data, rate_active
  );

  modport slave (
    input  enable, clear, rate, in_valid, in_data,
    output out_valid, out_data, rate_active
  );
endinterface
`default_nettype wire

// File: rtl/cic_decimator_n.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cic_decimator_n : N-stage CIC decimator, run-time rate, pipelined comb
// Revision: 1.0
// ---------------------------------------------------------------------------
module cic_decimator_n #(
  parameter int N            = 2,
  parameter int MAX_R        = 8,
  parameter int D            = 1,
  parameter int INPUT_WIDTH  = 12,
  parameter int OUTPUT_WIDTH = 16
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  cic_decimator_n_if.slave bus
);
  localparam int ACC_WIDTH = INPUT_WIDTH + N * $clog2(MAX_R * D);
  localparam int RW        = $clog2(MAX_R + 1);
  localparam logic [RW-1:0] c_max_r = RW'(MAX_R);

  logic [ACC_WIDTH-1:0] r_integ [1:N];
  logic [ACC_WIDTH-1:0] r_comb  [1:N];
  logic [ACC_WIDTH-1:0] r_dly   [1:N][0:D-1];
  logic [N:1]           r_cvld;
  logic                 r_dec_vld;
  logic [RW-1:0]        r_cnt;
  logic [RW-1:0]        r_rate_active;
  logic                 r_out_valid;
  logic [OUTPUT_WIDTH-1:0] r_out_data;

  logic                        w_flush;
  logic                        w_accept;
  logic                        w_strobe;
  logic [RW-1:0]               w_rate_req;
  logic [RW-1:0]               w_rate_eff;
  logic signed [ACC_WIDTH-1:0] w_in_ext;
  logic [ACC_WIDTH-1:0]        w_istage [0:N-1];
  logic [ACC_WIDTH-1:0]        w_cx     [1:N];
  logic [N:1]                  w_cv;

  assign w_flush  = !rst_n || bus.clear;
  assign w_accept = bus.in_valid && bus.enable && !bus.clear;
  assign w_in_ext = ACC_WIDTH'(bus.in_data);

  always_comb begin
    w_rate_req = bus.rate;
    if (bus.rate == '0)
      w_rate_req = RW'(1);
    else if (bus.rate > c_max_r)
      w_rate_req = c_max_r;
  end

  // The first sample of a block sees the freshly latched rate, so a rate-1
  // block strobes on that very sample.
  assign w_rate_eff = (r_cnt == '0) ? w_rate_req : r_rate_active;
  assign w_strobe   = w_accept && (r_cnt == w_rate_eff - RW'(1));

  always_comb begin
    w_istage[0] = w_in_ext;
    for (int k = 1; k < N; k++)
      w_istage[k] = r_integ[k];
    w_cx[1] = r_integ[N];
    w_cv[1] = r_dec_vld;
    for (int k = 2; k <= N; k++) begin
      w_cx[k] = r_comb[k-1];
      w_cv[k] = r_cvld[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_cnt         <= '0;
      r_rate_active <= c_max_r;
      r_dec_vld     <= 1'b0;
      r_cvld        <= '0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      for (int k = 1; k <= N; k++) begin
        r_integ[k] <= '0;
        r_comb[k]  <= '0;
        for (int j = 0; j < D; j++)
          r_dly[k][j] <= '0;
      end
    end else begin
      if (w_accept) begin
        if (r_cnt == '0)
          r_rate_active <= w_rate_req;
        r_cnt <= w_strobe ? '0 : r_cnt + RW'(1);
        for (int k = 1; k <= N; k++)
          r_integ[k] <= r_integ[k] + w_istage[k-1];
      end
      r_dec_vld <= w_strobe;

      // Each comb delay line advances only on its own stage's valid.
      for (int k = 1; k <= N; k++) begin
        r_cvld[k] <= w_cv[k];
        if (w_cv[k]) begin
          r_comb[k]   <= w_cx[k] - r_dly[k][D-1];
          r_dly[k][0] <= w_cx[k];
          for (int j = 1; j < D; j++)
            r_dly[k][j] <= r_dly[k][j-1];
        end
      end

      r_out_valid <= r_cvld[N];
      if (r_cvld[N])
        r_out_data <= r_comb[N][ACC_WIDTH-1 -: OUTPUT_WIDTH];
    end
  end

  assign bus.out_valid   = r_out_valid;
  assign bus.out_data    = r_out_data;
  assign bus.rate_active = r_rate_active;
endmodule
`default_nettype wire
